// File: rtl/count_history_display.sv
// Keeps a short history of distinct counter values and scans it onto a
// common-anode 7-segment display. Digit 0 always shows the newest value.
module count_history_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cnt_in,
    input  logic              cnt_valid,
    input  logic              clear,
    input  logic              freeze,
    output logic [6:0]        seg_n,
    output logic              dp_n,
    output logic [DIGITS-1:0] an_n,
    output logic [3:0]        fill,
    output logic              new_flag
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0]     r_presc;
    logic [IW-1:0]     r_idx;
    logic [3:0]        r_fill;
    logic [3:0]        r_hist [DIGITS];
    logic [6:0]        r_seg;
    logic              r_dp;
    logic [DIGITS-1:0] r_an;
    logic              r_new;

    logic              w_capture;
    logic [3:0]        w_idx4;
    logic [3:0]        w_cur;
    logic [DIGITS-1:0] w_anNext;

    function automatic logic [6:0] hexGlyph(input logic [3:0] v);
        case (v)
            4'h0:    hexGlyph = 7'h40;
            4'h1:    hexGlyph = 7'h79;
            4'h2:    hexGlyph = 7'h24;
            4'h3:    hexGlyph = 7'h30;
            4'h4:    hexGlyph = 7'h19;
            4'h5:    hexGlyph = 7'h12;
            4'h6:    hexGlyph = 7'h02;
            4'h7:    hexGlyph = 7'h78;
            4'h8:    hexGlyph = 7'h00;
            4'h9:    hexGlyph = 7'h10;
            4'hA:    hexGlyph = 7'h08;
            4'hB:    hexGlyph = 7'h03;
            4'hC:    hexGlyph = 7'h46;
            4'hD:    hexGlyph = 7'h21;
            4'hE:    hexGlyph = 7'h06;
            default: hexGlyph = 7'h0E;
        endcase
    endfunction

    // An empty history accepts anything; otherwise only a changed value is taken.
    assign w_capture = cnt_valid && !freeze && !clear &&
                       ((r_fill == 4'd0) || (cnt_in != r_hist[0]));
    assign w_idx4    = 4'(r_idx);
    assign w_cur     = r_hist[r_idx];
    assign w_anNext  = ~(DIGITS'(1) << r_idx);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_fill  <= 4'd0;
            for (int i = 0; i < DIGITS; i++) r_hist[i] <= 4'd0;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
            r_an    <= '1;
            r_new   <= 1'b0;
        end else begin
            if (r_presc == PW'(SCAN_DIV - 1)) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            // All three display fields come from the same index, so they switch together.
            r_an  <= w_anNext;
            r_seg <= (w_idx4 < r_fill) ? hexGlyph(w_cur) : 7'h7F;
            r_dp  <= !((r_idx == '0) && (r_fill != 4'd0));
            r_new <= w_capture;

            if (clear) begin
                r_fill <= 4'd0;
                for (int i = 0; i < DIGITS; i++) r_hist[i] <= 4'd0;
            end else if (w_capture) begin
                r_hist[0] <= cnt_in;
                for (int i = 1; i < DIGITS; i++) r_hist[i] <= r_hist[i-1];
                r_fill <= (r_fill == 4'(DIGITS)) ? r_fill : r_fill + 4'd1;
            end
        end
    end

    assign seg_n    = r_seg;
    assign dp_n     = r_dp;
    assign an_n     = r_an;
    assign fill     = r_fill;
    assign new_flag = r_new;

endmodule

// File: doc/count_history_display.md
Name: count_history_display

Overview:
- Downstream consumer of the 4-bit ripple counter value.
- Captures each new count value into a DIGITS-deep history shift buffer and drives a time-multiplexed, common-anode 7-segment display with hex glyphs.
- Digit 0 always shows the newest value.
- Sits between the counter stage and the board display pins.

Parameters:
DIGITS, 4, number of display digits and history depth; legal 1..8
SCAN_DIV, 1000, clk cycles each digit stays lit; legal >=2

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
cnt_in  input  4  count value from upstream counter
cnt_valid  input  1  cnt_in sample strobe, one cycle per sample
clear  input  1  synchronous history clear
freeze  input  1  1 = ignore captures, display held
seg_n  output  7  active-low segments {g,f,e,d,c,b,a}, registered
dp_n  output  1  active-low decimal point, registered
an_n  output  DIGITS  active-low digit enables, one-hot-low, registered
fill  output  4  number of valid history entries, saturates at DIGITS
new_flag  output  1  one-cycle pulse on each capture

Behaviour:
- Reset (reset==0 at a clk edge):
  - prescaler=0, scan index=0, fill=0, all history entries=0.
  - seg_n=7'h7F, dp_n=1, an_n=all ones, new_flag=0.
  - reset overrides clear, freeze and cnt_valid.
- Capture condition: cnt_valid=1, freeze=0, clear=0, and either fill==0 or cnt_in != hist[0].
  - On capture: hist[0]<=cnt_in; hist[i]<=hist[i-1] for i=1..DIGITS-1; oldest entry dropped.
  - fill<=min(fill+1,DIGITS).
  - new_flag=1 for exactly the cycle after the capturing edge.
- Duplicate value (cnt_in==hist[0], fill>0): no shift, no new_flag.
- clear=1: all hist entries=0, fill=0, new_flag=0 next cycle.
  - clear beats a simultaneous cnt_valid; that sample is lost.
  - Scan state is unaffected.
- freeze=1: no captures, no new_flag; scanning and display continue unchanged.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1, then wraps.
  - On wrap, index advances 0..DIGITS-1, then wraps to 0.
- Output registers update every cycle from current index and history:
  - an_n: bit[index]=0, all others 1.
  - seg_n: hex glyph of hist[index] if index<fill, else 7'h7F (blank).
  - dp_n: 0 when index==0 and fill>0, else 1 (marks newest).
- an_n, seg_n and dp_n always change on the same edge; no mixed-digit cycle.
- Capture-to-display latency: a capture at edge N shows on seg_n from edge N+1 whenever that digit is scanned.
- Glyph table (seg_n):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Counter wrap (cnt_in 15 to 0) is an ordinary value change and is captured.
- Reset released mid-scan or mid-capture: state restarts from reset values; first active an_n (index 0) appears one cycle after release.

Test Plan:
- Reset behaviour, DIGITS=4, SCAN_DIV=4: hold reset=0 for 3 cycles -> seg_n=7F, an_n=4'b1111, fill=0. Release -> an_n=4'b1110 next cycle; each digit lit 4 cycles in order 1110,1101,1011,0111, then back to 1110.
- Capture sequence: strobe cnt_in 3,4,4,5 -> fill=3, new_flag pulses 3 times (not for repeated 4). While scanned: digit0 seg_n=12 with dp_n=0, digit1=19, digit2=30, digit3 blank (7F).
- Overflow and wrap: strobe cnt_in 14,15,0,1,2 -> fill=4. Digits show 2,1,0,F (seg_n 24,79,40,0E); 14 dropped.
- freeze then clear: freeze=1, strobe 9 -> no new_flag, display unchanged. clear=1 together with cnt_valid (cnt_in=7) -> fill=0, all digits blank, no new_flag.
- Mid-operation reset: reset=0 while digit2 active and fill=4 -> next cycle an_n=1111, seg_n=7F, fill=0. After release the next strobe is captured (fill==0 rule) even if equal to the old hist[0].
- Back-to-back strobes: cnt_valid high 4 consecutive cycles with cnt_in 1,2,3,4 -> all captured, new_flag high 4 consecutive cycles, hist = 4,3,2,1.
